// File: rtl/jb_uart_pkg.sv
// jb_uart_pkg: shared constants, framer state encoding and checksum helper
package jb_uart_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int FRAME_BYTES = 6;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} fsm_state_t;
  function automatic logic [7:0] frame_chk(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer that can chain bytes with no idle gap
module uart_tx_byte
  import jb_uart_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       uart_tx
);
  localparam int CW = $clog2(BAUD_DIV);
  fsm_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic w_end;
  assign w_end = r_cnt == CW'(BAUD_DIV - 1);
  assign tx_done = r_state == ST_STOP && w_end;
  // start/data/stop sequencing; a start accepted on the last stop cycle chains the next byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      uart_tx <= 1'b1;
    end else if (tx_start && (r_state == ST_IDLE || tx_done)) begin
      r_state <= ST_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= tx_byte;
      uart_tx <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      r_cnt <= w_end ? '0 : r_cnt + 1'b1;
      if (w_end) begin
        if (r_state == ST_START || (r_state == ST_DATA && r_bit != 3'd7)) begin
          uart_tx <= r_sh[0];
          r_sh    <= r_sh >> 1;
          r_bit   <= r_state == ST_DATA ? r_bit + 3'd1 : r_bit;
          r_state <= ST_DATA;
        end else if (r_state == ST_DATA) begin
          uart_tx <= 1'b1;
          r_state <= ST_STOP;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: rtl/cntlr_uart_framer.sv
// cntlr_uart_framer: sends each controller report as a 6-byte UART frame with a one-deep pending buffer
module cntlr_uart_framer
  import jb_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115200,
  parameter int BAUD_DIV    = CLK_FREQ_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cntlr_data_rdy,
  input  logic [31:0] cntlr_data,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  logic [39:0] r_frame;
  logic [2:0]  r_byte_idx;
  logic [31:0] r_pend;
  logic        r_pend_vld;
  logic        w_tx_done, w_frame_end, w_load_new, w_load_pend, w_load, w_next_byte, w_drop;
  logic [31:0] w_word;
  logic [7:0]  w_tx_byte;
  assign w_frame_end = w_tx_done && r_byte_idx == 3'(FRAME_BYTES - 1);
  assign w_load_new  = cntlr_data_rdy && (!busy || w_frame_end);
  assign w_load_pend = w_frame_end && !cntlr_data_rdy && r_pend_vld;
  assign w_load      = w_load_new || w_load_pend;
  assign w_next_byte = w_tx_done && !w_frame_end;
  assign w_word      = w_load_new ? cntlr_data : r_pend;
  assign w_tx_byte   = w_next_byte ? r_frame[39:32] : FRAME_HDR;
  assign w_drop      = cntlr_data_rdy && busy && r_pend_vld;
  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (w_load || w_next_byte),
    .tx_byte  (w_tx_byte),
    .tx_done  (w_tx_done),
    .uart_tx  (uart_tx)
  );
  // frame register holds the bytes after the header; it shifts up one byte per byte sent
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame    <= '0;
      r_byte_idx <= '0;
      busy       <= 1'b0;
    end else if (w_load) begin
      r_frame    <= {w_word, frame_chk(w_word)};
      r_byte_idx <= '0;
      busy       <= 1'b1;
    end else if (w_next_byte) begin
      r_frame    <= {r_frame[31:0], 8'h00};
      r_byte_idx <= r_byte_idx + 3'd1;
    end else if (w_frame_end) begin
      busy <= 1'b0;
    end
  end
  // pending word is consumed or discarded at every frame end; overwrites and discards count as drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      r_pend     <= (cntlr_data_rdy && busy && !w_frame_end) ? cntlr_data : r_pend;
      r_pend_vld <= (cntlr_data_rdy && busy && !w_frame_end) ? 1'b1 : w_frame_end ? 1'b0 : r_pend_vld;
      drop_cnt   <= (w_drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_cntlr_uart_framer.sv
// tb_cntlr_uart_framer: scenario and randomized checks of the UART framer against a frame-level model
module tb_cntlr_uart_framer;
  localparam int BD = 16;
  localparam longint F = 60 * BD;
  logic clk = 0, rst = 1, cntlr_data_rdy = 0;
  logic [31:0] cntlr_data = '0;
  logic uart_tx, busy;
  logic [7:0] drop_cnt;
  int n_chk = 0, n_fail = 0;
  longint cyc = 0;
  logic [7:0] rx_q[$];
  longint rx_t[$];
  int rx_bad = 0;
  int blen = 0, last_blen = 0;
  bit m_busy = 0, m_pv = 0;
  logic [31:0] m_pw = '0;
  longint m_end = 0;
  int m_drops = 0;
  logic [31:0] exp_w[$];
  longint exp_t[$];

  cntlr_uart_framer #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .cntlr_data_rdy(cntlr_data_rdy), .cntlr_data(cntlr_data),
    .uart_tx(uart_tx), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  always @(negedge clk)
    if (busy === 1'b1) blen++;
    else if (blen != 0) begin last_blen = blen; blen = 0; end

  always begin : rx
    logic [7:0] b;
    logic v;
    bit ok, ab;
    longint st;
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      st = cyc; ok = 1; ab = 0; b = '0; v = 0;
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < BD; j++) begin
          if (i != 0 || j != 0) @(negedge clk);
          if (rst) ab = 1;
          if (j == 0) v = uart_tx;
          else if (uart_tx !== v) ok = 0;
          if (j == BD - 1) begin
            if ((i == 0 && v !== 1'b0) || (i == 9 && v !== 1'b1)) ok = 0;
            if (i > 0 && i < 9) b[i-1] = v;
          end
        end
      if (!ab) begin
        rx_q.push_back(b);
        rx_t.push_back(st);
        if (!ok) rx_bad++;
      end
    end
  end

  function automatic logic [47:0] frame_of(input logic [31:0] w);
    return {8'hA5, w, w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]};
  endfunction

  task automatic m_start(input logic [31:0] d, input longint e);
    exp_w.push_back(d);
    exp_t.push_back(e);
    m_busy = 1;
    m_end = e + F;
  endtask

  task automatic model_edge(input logic s, input logic [31:0] d, input longint e);
    if (m_busy && e == m_end) begin
      if (s) begin
        if (m_pv && m_drops < 255) m_drops++;
        m_pv = 0;
        m_start(d, e);
      end else if (m_pv) begin
        m_pv = 0;
        m_start(m_pw, e);
      end else m_busy = 0;
    end else if (!m_busy) begin
      if (s) m_start(d, e);
    end else if (s) begin
      if (m_pv && m_drops < 255) m_drops++;
      m_pw = d;
      m_pv = 1;
    end
  endtask

  task automatic tick(input logic s, input logic [31:0] d);
    cntlr_data_rdy = s;
    cntlr_data = d;
    if (!rst) model_edge(s, d, cyc + 1);
    @(negedge clk);
    cntlr_data_rdy = 0;
  endtask

  task automatic clr;
    exp_w.delete(); exp_t.delete(); rx_q.delete(); rx_t.delete(); rx_bad = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((m_busy || busy !== 1'b0) && k < 20 * F) begin tick(0, '0); k++; end
    repeat (3) tick(0, '0);
    n_chk++;
    if (busy !== 1'b0 || m_busy) begin n_fail++; $display("FAIL %s idle timeout: busy %b", nm, busy); end
  endtask

  task automatic get_frame(output logic [47:0] f, output longint t, output bit ok);
    f = '0; t = -1; ok = rx_q.size() >= 6;
    if (ok) begin
      t = rx_t[0];
      for (int j = 0; j < 6; j++) begin
        f = {f[39:0], rx_q.pop_front()};
        if (rx_t.pop_front() != t + 10 * BD * j) ok = 0;
      end
    end
  endtask

  task automatic test_reset;
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset uart_tx: got %b want 1", uart_tx); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single;
    logic [47:0] f; longint t, e; bit ok; int w;
    clr;
    tick(1, 32'h8040_1234); e = cyc;
    n_chk++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL single first low: got %b want 0", uart_tx); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single busy rise: got %b want 1", busy); end
    w = 0;
    while (uart_tx === 1'b0 && w < 4 * BD) begin w++; tick(0, '0); end
    n_chk++; if (w != BD) begin n_fail++; $display("FAIL start bit width: got %0d want %0d", w, BD); end
    wait_idle("single");
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== 48'hA5_8040_1234_E6) begin n_fail++; $display("FAIL single frame: got %h want a580401234e6", f); end
    n_chk++; if (t != e) begin n_fail++; $display("FAIL single start cycle: got %0d want %0d", t, e); end
    n_chk++; if (last_blen != F) begin n_fail++; $display("FAIL single busy width: got %0d want %0d", last_blen, F); end
    n_chk++; if (rx_bad != 0) begin n_fail++; $display("FAIL single bit cells: got %0d bad bytes want 0", rx_bad); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL single drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_pending;
    logic [47:0] f; longint t, e; bit ok; logic [31:0] w1;
    clr; w1 = $urandom;
    tick(1, w1); e = cyc;
    repeat (2 * 10 * BD + 5) tick(0, '0);
    tick(1, 32'hDEAD_BEEF);
    wait_idle("pending");
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w1) || t != e) begin n_fail++; $display("FAIL pending frame1: got %h @%0d want %h @%0d", f, t, frame_of(w1), e); end
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== 48'hA5_DEAD_BEEF_22 || t != e + F) begin n_fail++; $display("FAIL pending frame2: got %h @%0d want a5deadbeef22 @%0d", f, t, e + F); end
    n_chk++; if (last_blen != 2 * F) begin n_fail++; $display("FAIL pending busy width: got %0d want %0d", last_blen, 2 * F); end
    n_chk++; if (drop_cnt !== 8'd0 || rx_bad != 0) begin n_fail++; $display("FAIL pending drops/cells: got %0d/%0d want 0/0", drop_cnt, rx_bad); end
  endtask

  task automatic test_overwrite;
    logic [47:0] f; longint t, e; bit ok; logic [31:0] w; int base;
    clr; w = $urandom; base = drop_cnt;
    tick(1, w); e = cyc;
    repeat (50) tick(0, '0); tick(1, 32'd1);
    repeat (100) tick(0, '0); tick(1, 32'd2);
    repeat (200) tick(0, '0); tick(1, 32'd3);
    wait_idle("overwrite");
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w) || t != e) begin n_fail++; $display("FAIL overwrite frame1: got %h @%0d want %h @%0d", f, t, frame_of(w), e); end
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== 48'hA5_0000_0003_03 || t != e + F) begin n_fail++; $display("FAIL overwrite frame2: got %h @%0d want a50000000303 @%0d", f, t, e + F); end
    n_chk++; if (drop_cnt != base + 2) begin n_fail++; $display("FAIL overwrite drop_cnt: got %0d want %0d", drop_cnt, base + 2); end
  endtask

  task automatic test_coincide;
    logic [47:0] f; longint t, e; bit ok; logic [31:0] w1, w2, w3, w4; int base;
    clr; base = drop_cnt;
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom;
    tick(1, w1); e = cyc;
    repeat (F - 1) tick(0, '0);
    tick(1, w2);
    repeat (100) tick(0, '0);
    tick(1, w3);
    repeat (e + 2 * F - 1 - cyc) tick(0, '0);
    tick(1, w4);
    wait_idle("coincide");
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w1) || t != e) begin n_fail++; $display("FAIL coincide frame1: got %h @%0d want %h @%0d", f, t, frame_of(w1), e); end
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w2) || t != e + F) begin n_fail++; $display("FAIL coincide frame2: got %h @%0d want %h @%0d", f, t, frame_of(w2), e + F); end
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w4) || t != e + 2 * F) begin n_fail++; $display("FAIL coincide frame3: got %h @%0d want %h @%0d", f, t, frame_of(w4), e + 2 * F); end
    n_chk++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL coincide extra bytes: got %0d want 0", rx_q.size()); end
    n_chk++; if (drop_cnt != base + 1) begin n_fail++; $display("FAIL coincide drop_cnt: got %0d want %0d", drop_cnt, base + 1); end
    n_chk++; if (last_blen != 3 * F) begin n_fail++; $display("FAIL coincide busy width: got %0d want %0d", last_blen, 3 * F); end
  endtask

  task automatic test_reset_mid;
    logic [47:0] f; longint t, e; bit ok; logic [31:0] w;
    clr;
    tick(1, $urandom);
    repeat (3 * 10 * BD + 3 * BD + BD / 2) tick(0, '0);
    rst = 1;
    @(negedge clk);
    n_chk++; if (uart_tx !== 1'b1 || busy !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid reset: got tx %b busy %b drop %0d want 1 0 0", uart_tx, busy, drop_cnt); end
    @(negedge clk);
    rst = 0;
    m_busy = 0; m_pv = 0; m_drops = 0;
    repeat (12 * BD) tick(0, '0);
    clr; w = $urandom;
    tick(1, w); e = cyc;
    wait_idle("reset_mid");
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(w) || t != e || rx_bad != 0) begin n_fail++; $display("FAIL post-reset frame: got %h @%0d want %h @%0d", f, t, frame_of(w), e); end
  endtask

  task automatic test_saturate;
    logic [47:0] f; longint t, e; bit ok;
    clr;
    tick(1, $urandom); e = cyc;
    repeat (10) tick(0, '0);
    for (int i = 0; i <= 300; i++) begin
      tick(1, 32'(i + 1));
      if (i == 254) begin
        n_chk++; if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL saturate pre: got %0d want 254", drop_cnt); end
      end
    end
    n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate hold: got %0d want 255", drop_cnt); end
    wait_idle("saturate");
    void'(rx_q.size());
    get_frame(f, t, ok);
    get_frame(f, t, ok);
    n_chk++; if (!ok || f !== frame_of(32'd301) || t != e + F) begin n_fail++; $display("FAIL saturate frame2: got %h @%0d want %h @%0d", f, t, frame_of(32'd301), e + F); end
  endtask

  task automatic test_random;
    logic [47:0] f; longint t, et; bit ok; logic [31:0] w; int bmis; bit s;
    clr; bmis = 0;
    for (int n = 0; n < 6000; n++) begin
      s = ($urandom_range(0, 299) == 0) || (m_busy && cyc + 1 == m_end && $urandom_range(0, 2) == 0);
      tick(s, $urandom);
      if (busy !== m_busy) bmis++;
    end
    wait_idle("random");
    n_chk++; if (bmis != 0) begin n_fail++; $display("FAIL random busy track: got %0d mismatching cycles want 0", bmis); end
    while (exp_w.size() > 0) begin
      w = exp_w.pop_front(); et = exp_t.pop_front();
      get_frame(f, t, ok);
      n_chk++; if (!ok || f !== frame_of(w) || t != et) begin n_fail++; $display("FAIL random frame: got %h @%0d want %h @%0d", f, t, frame_of(w), et); end
    end
    n_chk++; if (rx_q.size() != 0 || rx_bad != 0) begin n_fail++; $display("FAIL random leftover/cells: got %0d/%0d want 0/0", rx_q.size(), rx_bad); end
    n_chk++; if (drop_cnt != m_drops) begin n_fail++; $display("FAIL random drop_cnt: got %0d want %0d", drop_cnt, m_drops); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 0;
    repeat (2) tick(0, '0);
    test_single;
    test_pending;
    test_overwrite;
    test_coincide;
    test_reset_mid;
    test_saturate;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
